lspc_vram_arb: RTL and testbench

LSPC_VRAM_ARB -- requirements
Module: lspc_vram_arb

---
 rtl/lspc_vram_arb.sv | 141 ++++++++++++++
 tb/tb_lspc_vram_arb.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/lspc_vram_arb.sv
// VRAM access arbiter for the 68k VRAM port: the CPU writes through an address, data and modulo register,
// and each access is placed in a free slot of the zone selected by ADDR_REG[15]. Every write is followed by a read prefetch.
module lspc_vram_arb (
  input  logic        CLK_24M,
  input  logic        RESET,
  input  logic        REG_ADDR_WE,
  input  logic        REG_DATA_WE,
  input  logic        REG_MOD_WE,
  input  logic [15:0] REG_WDATA,
  input  logic        SLOW_SLOT,
  input  logic        FAST_SLOT,
  input  logic [15:0] SLOW_RDATA,
  input  logic [15:0] FAST_RDATA,
  output logic [14:0] VRAM_ADDR,
  output logic [15:0] VRAM_WDATA,
  output logic        SLOW_WE,
  output logic        FAST_WE,
  output logic        SLOW_RD,
  output logic        FAST_RD,
  output logic [15:0] READ_BUF,
  output logic [15:0] ADDR_REG,
  output logic [15:0] MOD_REG,
  output logic        BUSY,
  output logic        OVERRUN
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_WAIT = 3'd1;
  localparam logic [2:0] WR_ACC  = 3'd2;
  localparam logic [2:0] RD_WAIT = 3'd3;
  localparam logic [2:0] RD_ACC  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] mod_q, mod_d;
  logic [15:0] wbuf_q, wbuf_d;
  logic [15:0] rbuf_q, rbuf_d;
  logic [14:0] vaddr_q, vaddr_d;
  logic [15:0] vwdata_q, vwdata_d;
  logic        swe_q, swe_d, fwe_q, fwe_d;
  logic        srd_q, srd_d, frd_q, frd_d;
  logic        busy_q, busy_d;
  logic        ovr_q, ovr_d;
  logic        slot;
  logic        wr_phase;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    mod_d    = REG_MOD_WE ? REG_WDATA : mod_q;
    wbuf_d   = wbuf_q;
    rbuf_d   = rbuf_q;
    vaddr_d  = vaddr_q;
    vwdata_d = vwdata_q;
    swe_d    = 1'b0;
    fwe_d    = 1'b0;
    srd_d    = 1'b0;
    frd_d    = 1'b0;
    ovr_d    = ovr_q;
    slot     = addr_q[15] ? FAST_SLOT : SLOW_SLOT;
    wr_phase = (state_q == WR_WAIT) || (state_q == WR_ACC);

    // A write in flight locks out both address and data writes; either one is recorded as an overrun.
    if (wr_phase) begin
      if (REG_ADDR_WE || REG_DATA_WE) ovr_d = 1'b1;
      if (state_q == WR_ACC) begin
        addr_d  = addr_q + mod_q;
        state_d = RD_WAIT;
      end else if (slot) begin
        state_d  = WR_ACC;
        vaddr_d  = addr_q[14:0];
        vwdata_d = wbuf_q;
        fwe_d    = addr_q[15];
        swe_d    = ~addr_q[15];
      end
    end else if (REG_ADDR_WE) begin
      addr_d  = REG_WDATA;
      state_d = RD_WAIT;
      if (REG_DATA_WE) ovr_d = 1'b1;
    end else if (REG_DATA_WE) begin
      wbuf_d  = REG_WDATA;
      state_d = WR_WAIT;
    end else if (state_q == RD_ACC) begin
      // The read strobe still high identifies which bus is returning data.
      rbuf_d  = frd_q ? FAST_RDATA : SLOW_RDATA;
      state_d = IDLE;
    end else if ((state_q == RD_WAIT) && slot) begin
      state_d = RD_ACC;
      vaddr_d = addr_q[14:0];
      frd_d   = addr_q[15];
      srd_d   = ~addr_q[15];
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      mod_q    <= '0;
      wbuf_q   <= '0;
      rbuf_q   <= '0;
      vaddr_q  <= '0;
      vwdata_q <= '0;
      swe_q    <= 1'b0;
      fwe_q    <= 1'b0;
      srd_q    <= 1'b0;
      frd_q    <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      mod_q    <= mod_d;
      wbuf_q   <= wbuf_d;
      rbuf_q   <= rbuf_d;
      vaddr_q  <= vaddr_d;
      vwdata_q <= vwdata_d;
      swe_q    <= swe_d;
      fwe_q    <= fwe_d;
      srd_q    <= srd_d;
      frd_q    <= frd_d;
      busy_q   <= busy_d;
      ovr_q    <= ovr_d;
    end
  end

  assign VRAM_ADDR  = vaddr_q;
  assign VRAM_WDATA = vwdata_q;
  assign SLOW_WE    = swe_q;
  assign FAST_WE    = fwe_q;
  assign SLOW_RD    = srd_q;
  assign FAST_RD    = frd_q;
  assign READ_BUF   = rbuf_q;
  assign ADDR_REG   = addr_q;
  assign MOD_REG    = mod_q;
  assign BUSY       = busy_q;
  assign OVERRUN    = ovr_q;

endmodule

// File: tb/tb_lspc_vram_arb.sv
// Bench for lspc_vram_arb: directed scenarios followed by random traffic.
// Every cycle is checked against a pending-write / pending-read transaction model.
module tb_lspc_vram_arb;

  logic        CLK_24M = 1'b0;
  logic        RESET;
  logic        REG_ADDR_WE, REG_DATA_WE, REG_MOD_WE;
  logic [15:0] REG_WDATA;
  logic        SLOW_SLOT, FAST_SLOT;
  logic [15:0] SLOW_RDATA, FAST_RDATA;
  logic [14:0] VRAM_ADDR;
  logic [15:0] VRAM_WDATA;
  logic        SLOW_WE, FAST_WE, SLOW_RD, FAST_RD;
  logic [15:0] READ_BUF, ADDR_REG, MOD_REG;
  logic        BUSY, OVERRUN;

  lspc_vram_arb dut (
    .CLK_24M(CLK_24M), .RESET(RESET),
    .REG_ADDR_WE(REG_ADDR_WE), .REG_DATA_WE(REG_DATA_WE), .REG_MOD_WE(REG_MOD_WE),
    .REG_WDATA(REG_WDATA), .SLOW_SLOT(SLOW_SLOT), .FAST_SLOT(FAST_SLOT),
    .SLOW_RDATA(SLOW_RDATA), .FAST_RDATA(FAST_RDATA),
    .VRAM_ADDR(VRAM_ADDR), .VRAM_WDATA(VRAM_WDATA),
    .SLOW_WE(SLOW_WE), .FAST_WE(FAST_WE), .SLOW_RD(SLOW_RD), .FAST_RD(FAST_RD),
    .READ_BUF(READ_BUF), .ADDR_REG(ADDR_REG), .MOD_REG(MOD_REG),
    .BUSY(BUSY), .OVERRUN(OVERRUN)
  );

  always #5 CLK_24M = ~CLK_24M;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a write waiting for a slot, a read waiting for a slot, and at most one access on the bus.
  logic [15:0] m_addr, m_mod, m_wbuf, m_rbuf, e_vwdata;
  logic [14:0] e_vaddr;
  logic        m_ovr, m_pend_wr, m_pend_rd, m_fz;
  int          m_flight;  // 0 none, 1 write on bus, 2 read on bus
  logic        e_swe, e_fwe, e_srd, e_frd, e_busy;

  task automatic model_reset();
    m_addr = '0; m_mod = '0; m_wbuf = '0; m_rbuf = '0; e_vwdata = '0; e_vaddr = '0;
    m_ovr = 1'b0; m_pend_wr = 1'b0; m_pend_rd = 1'b0; m_fz = 1'b0; m_flight = 0;
    e_swe = 1'b0; e_fwe = 1'b0; e_srd = 1'b0; e_frd = 1'b0; e_busy = 1'b0;
  endtask

  task automatic model_step();
    logic [15:0] old_mod;
    logic        slot;
    old_mod = m_mod;
    slot = m_addr[15] ? FAST_SLOT : SLOW_SLOT;
    e_swe = 1'b0; e_fwe = 1'b0; e_srd = 1'b0; e_frd = 1'b0;
    if (REG_MOD_WE) m_mod = REG_WDATA;
    if (m_pend_wr || m_flight == 1) begin
      if (REG_ADDR_WE || REG_DATA_WE) m_ovr = 1'b1;
      if (m_flight == 1) begin
        m_addr = m_addr + old_mod;
        m_flight = 0;
        m_pend_rd = 1'b1;
      end else if (slot) begin
        m_flight = 1; m_pend_wr = 1'b0;
        e_vaddr = m_addr[14:0]; e_vwdata = m_wbuf;
        if (m_addr[15]) e_fwe = 1'b1; else e_swe = 1'b1;
      end
    end else if (REG_ADDR_WE) begin
      m_addr = REG_WDATA; m_flight = 0; m_pend_rd = 1'b1;
      if (REG_DATA_WE) m_ovr = 1'b1;
    end else if (REG_DATA_WE) begin
      m_wbuf = REG_WDATA; m_pend_wr = 1'b1; m_pend_rd = 1'b0; m_flight = 0;
    end else if (m_flight == 2) begin
      m_rbuf = m_fz ? FAST_RDATA : SLOW_RDATA;
      m_flight = 0;
    end else if (m_pend_rd && slot) begin
      m_flight = 2; m_fz = m_addr[15]; m_pend_rd = 1'b0;
      e_vaddr = m_addr[14:0];
      if (m_addr[15]) e_frd = 1'b1; else e_srd = 1'b1;
    end
    e_busy = m_pend_wr || m_pend_rd || (m_flight != 0);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("SLOW_WE", {15'd0, SLOW_WE}, {15'd0, e_swe});
    chk("FAST_WE", {15'd0, FAST_WE}, {15'd0, e_fwe});
    chk("SLOW_RD", {15'd0, SLOW_RD}, {15'd0, e_srd});
    chk("FAST_RD", {15'd0, FAST_RD}, {15'd0, e_frd});
    chk("VRAM_ADDR", {1'b0, VRAM_ADDR}, {1'b0, e_vaddr});
    chk("VRAM_WDATA", VRAM_WDATA, e_vwdata);
    chk("READ_BUF", READ_BUF, m_rbuf);
    chk("ADDR_REG", ADDR_REG, m_addr);
    chk("MOD_REG", MOD_REG, m_mod);
    chk("BUSY", {15'd0, BUSY}, {15'd0, e_busy});
    chk("OVERRUN", {15'd0, OVERRUN}, {15'd0, m_ovr});
  endtask

  task automatic tick();
    @(posedge CLK_24M);
    if (!RESET) model_step();
    #1;
    check_all();
    REG_ADDR_WE = 1'b0; REG_DATA_WE = 1'b0; REG_MOD_WE = 1'b0;
    SLOW_SLOT = 1'b0; FAST_SLOT = 1'b0;
    REG_WDATA = 16'($urandom);
    SLOW_RDATA = 16'($urandom); FAST_RDATA = 16'($urandom);
  endtask

  task automatic wr_addr(input logic [15:0] v); REG_ADDR_WE = 1'b1; REG_WDATA = v; tick(); endtask
  task automatic wr_mod(input logic [15:0] v);  REG_MOD_WE = 1'b1;  REG_WDATA = v; tick(); endtask
  task automatic wr_data(input logic [15:0] v); REG_DATA_WE = 1'b1; REG_WDATA = v; tick(); endtask
  task automatic slot_slow(); SLOW_SLOT = 1'b1; tick(); endtask
  task automatic slot_fast(); FAST_SLOT = 1'b1; tick(); endtask

  // Asynchronous reset raised between clock edges; outputs must clear before the next edge.
  task automatic do_reset();
    #2;
    RESET = 1'b1;
    #1;
    model_reset();
    check_all();
    tick();
    RESET = 1'b0;
    tick();
  endtask

  logic [15:0] saved_rbuf;

  initial begin
    RESET = 1'b1;
    REG_ADDR_WE = 1'b0; REG_DATA_WE = 1'b0; REG_MOD_WE = 1'b0; REG_WDATA = '0;
    SLOW_SLOT = 1'b0; FAST_SLOT = 1'b0; SLOW_RDATA = '0; FAST_RDATA = '0;
    model_reset();
    #2;
    check_all();
    tick();
    RESET = 1'b0;
    tick();

    // Write with modulo 1 on slow VRAM, then the prefetch.
    wr_addr(16'h7000); wr_mod(16'h0001); wr_data(16'h1234);
    slot_slow();
    chk("d29_swe", {15'd0, SLOW_WE}, 16'd1);
    chk("d29_vaddr", {1'b0, VRAM_ADDR}, 16'h7000);
    chk("d29_wdata", VRAM_WDATA, 16'h1234);
    tick();
    chk("d29_swe_off", {15'd0, SLOW_WE}, 16'd0);
    chk("d29_addr", ADDR_REG, 16'h7001);
    slot_slow();
    chk("d29_srd", {15'd0, SLOW_RD}, 16'd1);
    chk("d29_rvaddr", {1'b0, VRAM_ADDR}, 16'h7001);
    SLOW_RDATA = 16'hBEEF;
    tick();
    chk("d29_rbuf", READ_BUF, 16'hBEEF);
    chk("d29_busy", {15'd0, BUSY}, 16'd0);

    // Fast zone read ignores slow slots.
    wr_addr(16'h8400);
    slot_slow();
    chk("d30_nostrobe", {12'd0, SLOW_WE, FAST_WE, SLOW_RD, FAST_RD}, 16'd0);
    slot_fast();
    chk("d30_frd", {15'd0, FAST_RD}, 16'd1);
    chk("d30_vaddr", {1'b0, VRAM_ADDR}, 16'h0400);
    tick();

    // Address wrap crosses from fast to slow zone.
    wr_addr(16'hFFFF); wr_mod(16'h0002); wr_data(16'h5A5A);
    slot_fast();
    chk("d31_fwe", {15'd0, FAST_WE}, 16'd1);
    chk("d31_vaddr", {1'b0, VRAM_ADDR}, 16'h7FFF);
    tick();
    chk("d31_wrap", ADDR_REG, 16'h0001);
    slot_fast();
    chk("d31_ignore_fast", {15'd0, FAST_RD}, 16'd0);
    slot_slow();
    chk("d31_srd", {15'd0, SLOW_RD}, 16'd1);
    tick();

    // Back-to-back data writes: the second is dropped.
    wr_data(16'h1111); wr_data(16'h2222);
    chk("d32_ovr", {15'd0, OVERRUN}, 16'd1);
    slot_slow();
    chk("d32_wdata", VRAM_WDATA, 16'h1111);
    tick(); slot_slow(); tick();
    chk("d32_ovr_sticky", {15'd0, OVERRUN}, 16'd1);

    // Address write during a read access discards its data.
    wr_addr(16'h0005);
    slot_slow();
    saved_rbuf = m_rbuf;
    SLOW_RDATA = 16'hCAFE;
    wr_addr(16'h0010);
    chk("d33_rbuf_kept", READ_BUF, saved_rbuf);
    slot_slow();
    chk("d33_srd", {15'd0, SLOW_RD}, 16'd1);
    chk("d33_vaddr", {1'b0, VRAM_ADDR}, 16'h0010);
    tick();

    // Reset in the middle of a write access.
    wr_data(16'h7777);
    slot_slow();
    chk("d34_in_acc", {15'd0, SLOW_WE}, 16'd1);
    do_reset();
    chk("d34_ovr_clr", {15'd0, OVERRUN}, 16'd0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      REG_ADDR_WE = ($urandom_range(0, 9) == 0);
      REG_DATA_WE = ($urandom_range(0, 9) == 0);
      REG_MOD_WE  = ($urandom_range(0, 11) == 0);
      REG_WDATA   = 16'($urandom);
      SLOW_SLOT   = ($urandom_range(0, 2) == 0);
      FAST_SLOT   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      else tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
